// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_stage_reg instances: stage state encodings and
// the control-field layout every stage agrees on.
package pipe_pkg;

  typedef logic [1:0] stage_state_t;

  localparam stage_state_t ST_EMPTY = 2'd0;
  localparam stage_state_t ST_FULL  = 2'd1;
  localparam stage_state_t ST_SKID  = 2'd2;

  localparam int CTRL_W_DEF = 8;

  // Bit offsets inside the control field; flush/bubble zero all of them.
  localparam int CTRL_REGWRITE    = 0;
  localparam int CTRL_MEMWRITE    = 1;
  localparam int CTRL_RESULTSRC_LO = 2;
  localparam int CTRL_RESULTSRC_HI = 3;
  localparam int CTRL_BRANCH      = 4;
  localparam int CTRL_JUMP        = 5;
  localparam int CTRL_ALUSRC      = 6;
  localparam int CTRL_MEMREAD     = 7;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid bit, control field (cleared whenever the entry
// goes invalid) and data field (cleared on flush only when CLR_DATA=1).
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int DATA_W   = 144,
  parameter int CLR_DATA = 0
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Next-state selection; flush outranks load so a flushed input never lands.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLR_DATA != 0) begin
        data_d = '0;
      end else begin
        data_d = data_q;
      end
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, flush handling and saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int DATA_W   = 144,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_state_t      state_d, state_q;
  logic              in_xfer_s, out_xfer_s;
  logic              main_load_s, main_drop_s, main_from_skid_s;
  logic              skid_load_s, skid_drop_s, skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_s, main_ctrl_in_s;
  logic [DATA_W-1:0] skid_data_s, main_data_in_s;
  logic [CNT_W-1:0]  stall_d, stall_q, bubble_d, bubble_q;

  assign in_ready   = (SKID != 0) ? !skid_valid_s : (!out_valid | out_ready);
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid & out_ready;

  // Occupancy state machine: decides which entry loads or drops this cycle.
  always_comb begin
    state_d          = state_q;
    main_load_s      = 1'b0;
    main_drop_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_drop_s      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          main_load_s = 1'b1;
          state_d     = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (in_xfer_s && out_xfer_s) begin
          main_load_s = 1'b1;
        end else if (in_xfer_s && (SKID != 0)) begin
          skid_load_s = 1'b1;
          state_d     = ST_SKID;
        end else if (out_xfer_s) begin
          main_drop_s = 1'b1;
          state_d     = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_SKID: begin
        if (out_xfer_s) begin
          main_load_s      = 1'b1;
          main_from_skid_s = 1'b1;
          skid_drop_s      = 1'b1;
          state_d          = ST_FULL;
        end else begin
          state_d = ST_SKID;
        end
      end
      default: begin
        main_drop_s = 1'b1;
        skid_drop_s = 1'b1;
        state_d     = ST_EMPTY;
      end
    endcase
  end

  assign main_ctrl_in_s = main_from_skid_s ? skid_ctrl_s : in_ctrl;
  assign main_data_in_s = main_from_skid_s ? skid_data_s : in_data;

  // Saturating performance counters; they keep counting through flush.
  always_comb begin
    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (!out_valid && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_ONE;
    end else begin
      bubble_d = bubble_q;
    end
  end

  // State and counter registers; clr outranks flush.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_EMPTY;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= flush ? ST_EMPTY : state_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  pipe_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .clk_i   (clk),
    .clr_i   (clr),
    .flush_i (flush),
    .load_i  (main_load_s),
    .drop_i  (main_drop_s),
    .ctrl_i  (main_ctrl_in_s),
    .data_i  (main_data_in_s),
    .valid_o (out_valid),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
      ) u_skid (
        .clk_i   (clk),
        .clr_i   (clr),
        .flush_i (flush),
        .load_i  (skid_load_s),
        .drop_i  (skid_drop_s),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid_s),
        .ctrl_o  (skid_ctrl_s),
        .data_o  (skid_data_s)
      );
    end else begin : g_noskid
      logic unused_skid_s;
      assign unused_skid_s = skid_load_s ^ skid_drop_s;
      assign skid_valid_s  = 1'b0;
      assign skid_ctrl_s   = '0;
      assign skid_data_s   = '0;
    end
  endgenerate

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: two SKID=1 instances (CLR_DATA=0/CNT_W=16 and CLR_DATA=1/CNT_W=4)
// sharing stimulus, plus a SKID=0 instance with its own handshake inputs.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        clr, flush, in_valid, out_ready;
  logic [7:0]  in_ctrl;
  logic [15:0] in_data;

  logic        in_ready_a, out_valid_a;
  logic [7:0]  out_ctrl_a;
  logic [15:0] out_data_a, stall_a, bubble_a;

  logic        in_ready_b, out_valid_b;
  logic [7:0]  out_ctrl_b;
  logic [15:0] out_data_b;
  logic [3:0]  stall_b, bubble_b;

  logic        in_valid0, out_ready0, in_ready0, out_valid0;
  logic [7:0]  out_ctrl0;
  logic [15:0] out_data0, stall0, bubble0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(1), .CLR_DATA(0), .CNT_W(16)) u_dut_a (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_ctrl(out_ctrl_a), .out_data(out_data_a), .stall_cnt(stall_a), .bubble_cnt(bubble_a)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(1), .CLR_DATA(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ctrl(out_ctrl_b), .out_data(out_data_b), .stall_cnt(stall_b), .bubble_cnt(bubble_b)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(0), .CLR_DATA(0), .CNT_W(16)) u_dut_0 (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .stall_cnt(stall0), .bubble_cnt(bubble0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [15:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    drive(1'b0, 8'h00, 16'h0000);
    step();
    step();
    clr = 1'b0;

    // Reset state
    chk("rst_valid", 64'(out_valid_a), 64'h0);
    chk("rst_ctrl", 64'(out_ctrl_a), 64'h0);
    chk("rst_data", 64'(out_data_a), 64'h0);
    chk("rst_stall", 64'(stall_a), 64'h0);
    chk("rst_bubble", 64'(bubble_a), 64'h0);
    chk("rst_in_ready", 64'(in_ready_a), 64'h1);

    // 1. Streaming with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 16'h0100 + 16'(i));
      chk("strm_in_ready", 64'(in_ready_a), 64'h1);
      step();
      chk("strm_valid", 64'(out_valid_a), 64'h1);
      chk("strm_ctrl", 64'(out_ctrl_a), 64'(i));
      chk("strm_data", 64'(out_data_a), 64'h100 + 64'(i));
    end
    drive(1'b0, 8'h00, 16'h0000);
    step();
    chk("strm_drain", 64'(out_valid_a), 64'h0);
    chk("strm_stall", 64'(stall_a), 64'h0);

    // 2. Back-pressure: A, B, C with out_ready low for 3 cycles after A shows
    drive(1'b1, 8'hA1, 16'hAAAA);
    step();
    chk("bp_a_out", 64'(out_data_a), 64'hAAAA);
    out_ready = 1'b0;
    drive(1'b1, 8'hB2, 16'hBBBB);
    step();
    chk("bp_in_ready_lo", 64'(in_ready_a), 64'h0);
    chk("bp_a_hold1", 64'(out_data_a), 64'hAAAA);
    drive(1'b1, 8'hC3, 16'hCCCC);
    step();
    chk("bp_a_hold2", 64'(out_data_a), 64'hAAAA);
    chk("bp_a_ctrl", 64'(out_ctrl_a), 64'hA1);
    step();
    chk("bp_a_hold3", 64'(out_data_a), 64'hAAAA);
    chk("bp_stall_a", 64'(stall_a), 64'h3);
    chk("bp_stall_b", 64'(stall_b), 64'h3);
    out_ready = 1'b1;
    step();
    chk("bp_b_out", 64'(out_data_a), 64'hBBBB);
    chk("bp_b_ctrl", 64'(out_ctrl_a), 64'hB2);
    chk("bp_in_ready_hi", 64'(in_ready_a), 64'h1);
    step();
    chk("bp_c_out", 64'(out_data_a), 64'hCCCC);
    chk("bp_c_valid", 64'(out_valid_a), 64'h1);
    drive(1'b0, 8'h00, 16'h0000);
    step();
    chk("bp_drain", 64'(out_valid_a), 64'h0);
    chk("bp_stall_final", 64'(stall_a), 64'h3);

    // 3. Flush while in SKID state, with a simultaneous input
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 16'h1111);
    step();
    drive(1'b1, 8'h22, 16'h2222);
    step();
    chk("fl_skid_ready", 64'(in_ready_a), 64'h0);
    flush = 1'b1;
    drive(1'b1, 8'h33, 16'hDEAD);
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 16'h0000);
    chk("fl_valid_a", 64'(out_valid_a), 64'h0);
    chk("fl_ctrl_a", 64'(out_ctrl_a), 64'h0);
    chk("fl_data_hold_a", 64'(out_data_a), 64'h1111);
    chk("fl_valid_b", 64'(out_valid_b), 64'h0);
    chk("fl_data_zero_b", 64'(out_data_b), 64'h0);
    chk("fl_in_ready", 64'(in_ready_a), 64'h1);
    step();
    chk("fl_no_dead_valid", 64'(out_valid_a), 64'h0);
    chk("fl_no_dead_data", 64'(out_data_a), 64'h1111);

    // 4. clr and flush together while FULL
    out_ready = 1'b1;
    drive(1'b1, 8'h5A, 16'h5A5A);
    step();
    chk("rp_full", 64'(out_valid_a), 64'h1);
    clr = 1'b1;
    flush = 1'b1;
    step();
    clr = 1'b0;
    flush = 1'b0;
    drive(1'b0, 8'h00, 16'h0000);
    chk("rp_valid", 64'(out_valid_a), 64'h0);
    chk("rp_ctrl", 64'(out_ctrl_a), 64'h0);
    chk("rp_data", 64'(out_data_a), 64'h0);
    chk("rp_stall", 64'(stall_a), 64'h0);
    chk("rp_bubble", 64'(bubble_a), 64'h0);
    chk("rp_in_ready", 64'(in_ready_a), 64'h1);

    // 5. Idle for 20 cycles: 4-bit bubble counter saturates at 15
    for (int i = 0; i < 20; i++) step();
    chk("sat_b_15", 64'(bubble_b), 64'hF);
    chk("sat_a_20", 64'(bubble_a), 64'd20);
    for (int i = 0; i < 3; i++) step();
    chk("sat_b_stick", 64'(bubble_b), 64'hF);
    chk("sat_a_23", 64'(bubble_a), 64'd23);

    // 6. SKID=0: combinational in_ready
    in_valid0 = 1'b1;
    out_ready0 = 1'b0;
    in_ctrl = 8'h44;
    in_data = 16'h4444;
    #1;
    chk("s0_empty_ready", 64'(in_ready0), 64'h1);
    step();
    chk("s0_first", 64'(out_data0), 64'h4444);
    in_ctrl = 8'h55;
    in_data = 16'h5555;
    #1;
    chk("s0_ready_lo", 64'(in_ready0), 64'h0);
    step();
    chk("s0_hold", 64'(out_data0), 64'h4444);
    chk("s0_hold_ctrl", 64'(out_ctrl0), 64'h44);
    out_ready0 = 1'b1;
    #1;
    chk("s0_ready_comb", 64'(in_ready0), 64'h1);
    step();
    chk("s0_second", 64'(out_data0), 64'h5555);
    chk("s0_second_ctrl", 64'(out_ctrl0), 64'h55);
    chk("s0_stall", 64'(stall0), 64'h1);
    in_valid0 = 1'b0;
    step();
    chk("s0_drain", 64'(out_valid0), 64'h0);
    chk("s0_drain_ctrl", 64'(out_ctrl0), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
